// File: rtl/kernel_sdiv_32s_32s_32_seq_pkg.sv
// Shared definitions for the sequential signed divider: state encoding and constants.
package kernel_sdiv_32s_32s_32_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    // One restoring step per quotient bit.
    localparam int unsigned DIV_ITERS = 32;

    // Quotient reported for a zero divisor.
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/kernel_sdiv_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module kernel_sdiv_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] prem_i,
    input  logic             bit_i,
    input  logic [Width-1:0] div_i,
    output logic [Width-1:0] prem_o,
    output logic             qbit_o
);

    // The partial remainder is always below the divisor, so the shifted value is below
    // twice the divisor and a Width+1 bit trial difference has an unambiguous sign bit.
    logic [Width:0] shifted;
    logic [Width:0] trial;

    // Trial-subtract; keep the difference when it is non-negative, otherwise restore.
    always_comb begin
        shifted = {prem_i, bit_i};
        trial   = shifted - {1'b0, div_i};
        qbit_o  = ~trial[Width];
        prem_o  = qbit_o ? trial[Width-1:0] : shifted[Width-1:0];
    end

endmodule

// File: rtl/kernel_sdiv_32s_32s_32_seq.sv
// Sequential signed divider: magnitude restoring division followed by sign correction.
module kernel_sdiv_32s_32s_32_seq
    import kernel_sdiv_32s_32s_32_seq_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH = 32,
    parameter int unsigned DIN1_WIDTH = 32,
    parameter int unsigned DOUT_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [DOUT_WIDTH-1:0] rem
);

    localparam int unsigned W    = DIN0_WIDTH;
    localparam int unsigned CntW = $clog2(DIV_ITERS);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [W-1:0]    prem_q;   // partial remainder
    logic [W-1:0]    quo_q;    // dividend bits shift out the top, quotient bits shift in
    logic [W-1:0]    div_q;    // divisor magnitude
    logic [W-1:0]    dvd_q;    // raw dividend, returned as remainder on a zero divisor
    logic            qneg_q;
    logic            rneg_q;
    logic            zero_q;
    logic [W-1:0]    dout_q;
    logic [W-1:0]    rem_q;
    logic            done_q;

    logic [W-1:0]    din0_mag;
    logic [W-1:0]    din1_mag;
    logic [W-1:0]    step_prem;
    logic            step_qbit;

    // Unsigned magnitudes; -2^31 maps to 0x80000000 exactly.
    always_comb begin
        din0_mag = din0[DIN0_WIDTH-1] ? -din0 : din0;
        din1_mag = din1[DIN1_WIDTH-1] ? -din1 : din1;
    end

    kernel_sdiv_step #(
        .Width (W)
    ) u_step (
        .prem_i (prem_q),
        .bit_i  (quo_q[W-1]),
        .div_i  (div_q),
        .prem_o (step_prem),
        .qbit_o (step_qbit)
    );

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            dvd_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ap_start) begin
                        state_q <= StCalc;
                        cnt_q   <= '0;
                        prem_q  <= '0;
                        quo_q   <= din0_mag;
                        div_q   <= din1_mag;
                        dvd_q   <= din0;
                        qneg_q  <= din0[DIN0_WIDTH-1] ^ din1[DIN1_WIDTH-1];
                        rneg_q  <= din0[DIN0_WIDTH-1];
                        zero_q  <= (din1 == '0);
                    end
                end
                StCalc: begin
                    prem_q <= step_prem;
                    quo_q  <= {quo_q[W-2:0], step_qbit};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(DIV_ITERS - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    // -2^31 / -1 wraps to 0x80000000 through the plain negate.
                    if (zero_q) begin
                        dout_q <= DIV0_QUOT;
                        rem_q  <= dvd_q;
                    end else begin
                        dout_q <= qneg_q ? -quo_q : quo_q;
                        rem_q  <= rneg_q ? -prem_q : prem_q;
                    end
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ap_idle = (state_q == StIdle);
    assign ap_done = done_q;
    assign dout    = dout_q;
    assign rem     = rem_q;

endmodule
